// File: rtl/report_checker.sv
// Collects one report of levels per transfer, then decides whether the report is
// safe, optionally after dropping a single level, and keeps running safe/unsafe tallies.
module report_checker #(
   parameter int WIDTH      = 8,
   parameter int MAX_LEVELS = 16,
   parameter int MIN_STEP   = 1,
   parameter int MAX_STEP   = 3,
   parameter int DAMPEN     = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             res_valid,
   output logic             res_safe,
   output logic             res_dampened,
   output logic             res_overflow,
   output logic [CNT_W-1:0] safe_count,
   output logic [CNT_W-1:0] unsafe_count
);

   localparam int NW = $clog2(MAX_LEVELS + 1);
   localparam int IW = (MAX_LEVELS > 1) ? $clog2(MAX_LEVELS) : 1;
   localparam logic [NW-1:0]    N_MAX   = NW'(MAX_LEVELS);
   localparam logic [WIDTH:0]   STEP_LO = (WIDTH+1)'(MIN_STEP);
   localparam logic [WIDTH:0]   STEP_HI = (WIDTH+1)'(MAX_STEP);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   typedef enum logic [1:0] {COLLECT, EVAL, RESULT} state_t;

   state_t           state;
   logic [WIDTH-1:0] levels [MAX_LEVELS];
   logic [NW-1:0]    n;
   logic [NW-1:0]    pos;
   logic [NW-1:0]    skip_idx;
   logic             ovf;
   logic             skip_en;
   logic             have_prev;
   logic             have_dir;
   logic             dir_up;
   logic [WIDTH-1:0] prev;

   logic [WIDTH-1:0] cur;
   logic [NW-1:0]    n_last;
   logic [WIDTH:0]   mag;
   logic             skip_here;
   logic             cur_up;
   logic             step_ok;
   logic             pair_bad;
   logic             pass_done;

   assign in_ready = (state == COLLECT) && !rst;

   // One pair per cycle: prev is the last kept level of the current pass, cur the candidate.
   always_comb begin
      cur       = levels[pos[IW-1:0]];
      n_last    = n - NW'(1);
      skip_here = skip_en && (pos == skip_idx);
      cur_up    = cur > prev;
      mag       = cur_up ? ({1'b0, cur} - {1'b0, prev}) : ({1'b0, prev} - {1'b0, cur});
      step_ok   = (cur != prev) && (mag >= STEP_LO) && (mag <= STEP_HI);
      pair_bad  = !skip_here && have_prev && (!step_ok || (have_dir && (cur_up != dir_up)));
      pass_done = pair_bad || (pos == n_last);
   end

   always_ff @(posedge clk) begin
      if (state == COLLECT && in_valid && n != N_MAX) begin
         levels[n[IW-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= COLLECT;
         n            <= '0;
         pos          <= '0;
         skip_idx     <= '0;
         ovf          <= 1'b0;
         skip_en      <= 1'b0;
         have_prev    <= 1'b0;
         have_dir     <= 1'b0;
         dir_up       <= 1'b0;
         prev         <= '0;
         res_valid    <= 1'b0;
         res_safe     <= 1'b0;
         res_dampened <= 1'b0;
         res_overflow <= 1'b0;
         safe_count   <= '0;
         unsafe_count <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (in_valid) begin
                  if (n == N_MAX) begin
                     ovf <= 1'b1;
                  end else begin
                     n <= n + NW'(1);
                  end
                  if (in_last) begin
                     state     <= EVAL;
                     pos       <= '0;
                     skip_en   <= 1'b0;
                     skip_idx  <= '0;
                     have_prev <= 1'b0;
                     have_dir  <= 1'b0;
                  end
               end
            end

            EVAL: begin
               if (ovf) begin
                  state        <= RESULT;
                  res_valid    <= 1'b1;
                  res_safe     <= 1'b0;
                  res_dampened <= 1'b0;
                  res_overflow <= 1'b1;
               end else if (!pass_done) begin
                  pos <= pos + NW'(1);
                  if (!skip_here) begin
                     prev      <= cur;
                     have_prev <= 1'b1;
                     if (have_prev && !have_dir) begin
                        have_dir <= 1'b1;
                        dir_up   <= cur_up;
                     end
                  end
               end else if (!pair_bad) begin
                  state        <= RESULT;
                  res_valid    <= 1'b1;
                  res_safe     <= 1'b1;
                  res_dampened <= skip_en;
                  res_overflow <= 1'b0;
               end else if ((!skip_en && DAMPEN != 0) || (skip_en && skip_idx != n_last)) begin
                  // Failed pass with removals left to try: restart with the next index dropped.
                  skip_idx  <= skip_en ? skip_idx + NW'(1) : '0;
                  skip_en   <= 1'b1;
                  pos       <= '0;
                  have_prev <= 1'b0;
                  have_dir  <= 1'b0;
               end else begin
                  state        <= RESULT;
                  res_valid    <= 1'b1;
                  res_safe     <= 1'b0;
                  res_dampened <= 1'b0;
                  res_overflow <= 1'b0;
               end
            end

            RESULT: begin
               state     <= COLLECT;
               res_valid <= 1'b0;
               n         <= '0;
               ovf       <= 1'b0;
               if (res_safe) begin
                  if (safe_count != CNT_SAT) safe_count <= safe_count + CNT_W'(1);
               end else begin
                  if (unsafe_count != CNT_SAT) unsafe_count <= unsafe_count + CNT_W'(1);
               end
            end

            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_report_checker.sv
// Drives four report_checker variants (default, no dampening, 4-deep buffer, 2-bit counters)
// and compares every result against a list-based reference of the safety rules.
module tb_report_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid     [4];
   logic [7:0]  in_data      [4];
   logic        in_last      [4];
   logic        in_ready     [4];
   logic        res_valid    [4];
   logic        res_safe     [4];
   logic        res_dampened [4];
   logic        res_overflow [4];
   logic [15:0] safe_cnt16   [3];
   logic [15:0] unsafe_cnt16 [3];
   logic [1:0]  safe_cnt2;
   logic [1:0]  unsafe_cnt2;

   int total = 0;
   int bad   = 0;
   int expSafe   [4];
   int expUnsafe [4];

   report_checker dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .in_last(in_last[0]), .res_valid(res_valid[0]),
      .res_safe(res_safe[0]), .res_dampened(res_dampened[0]), .res_overflow(res_overflow[0]),
      .safe_count(safe_cnt16[0]), .unsafe_count(unsafe_cnt16[0]));

   report_checker #(.DAMPEN(0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .in_last(in_last[1]), .res_valid(res_valid[1]),
      .res_safe(res_safe[1]), .res_dampened(res_dampened[1]), .res_overflow(res_overflow[1]),
      .safe_count(safe_cnt16[1]), .unsafe_count(unsafe_cnt16[1]));

   report_checker #(.MAX_LEVELS(4)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .in_last(in_last[2]), .res_valid(res_valid[2]),
      .res_safe(res_safe[2]), .res_dampened(res_dampened[2]), .res_overflow(res_overflow[2]),
      .safe_count(safe_cnt16[2]), .unsafe_count(unsafe_cnt16[2]));

   report_checker #(.CNT_W(2)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .in_data(in_data[3]), .in_last(in_last[3]), .res_valid(res_valid[3]),
      .res_safe(res_safe[3]), .res_dampened(res_dampened[3]), .res_overflow(res_overflow[3]),
      .safe_count(safe_cnt2), .unsafe_count(unsafe_cnt2));

   task automatic checkOutput(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int getSafe(input int w);
      if (w == 3) return int'(safe_cnt2);
      return int'(safe_cnt16[w]);
   endfunction

   function automatic int getUnsafe(input int w);
      if (w == 3) return int'(unsafe_cnt2);
      return int'(unsafe_cnt16[w]);
   endfunction

   function automatic bit seqSafe(input int q[$]);
      int firstSign = 0;
      for (int i = 1; i < q.size(); i++) begin
         int d  = q[i] - q[i-1];
         int ad = (d < 0) ? -d : d;
         int s  = (d > 0) ? 1 : -1;
         if (d == 0 || ad < 1 || ad > 3) return 1'b0;
         if (i == 1) firstSign = s;
         else if (s != firstSign) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic evalReport(input int q[$], input int dampen, input int maxl,
                             output bit s, output bit d, output bit o);
      s = 1'b0; d = 1'b0; o = 1'b0;
      if (q.size() > maxl) begin
         o = 1'b1;
      end else if (seqSafe(q)) begin
         s = 1'b1;
      end else if (dampen != 0) begin
         for (int k = 0; k < q.size(); k++) begin
            int r[$];
            r = q;
            r.delete(k);
            if (!s && seqSafe(r)) begin
               s = 1'b1;
               d = 1'b1;
            end
         end
      end
   endtask

   task automatic applyStimulus(input int w, input int q[$], input bit withLast);
      for (int i = 0; i < q.size(); i++) begin
         int guard = 0;
         @(negedge clk);
         while (!in_ready[w] && guard < 2000) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 2000) checkOutput($sformatf("dut%0d_ready_wait", w), 0, 1);
         in_valid[w] = 1'b1;
         in_data[w]  = 8'(q[i]);
         in_last[w]  = withLast && (i == q.size() - 1);
      end
      @(negedge clk);
      in_valid[w] = 1'b0;
      in_last[w]  = 1'b0;
   endtask

   task automatic runReport(input int w, input int q[$]);
      bit s, d, o;
      int budget, k, maxl, sat;
      maxl = (w == 2) ? 4 : 16;
      sat  = (w == 3) ? 3 : 65535;
      evalReport(q, (w == 1) ? 0 : 1, maxl, s, d, o);
      applyStimulus(w, q, 1'b1);
      budget = (q.size() + 1) * (q.size() + 1) + 2;
      k = 0;
      while (!res_valid[w] && k < budget) begin
         @(negedge clk);
         k++;
      end
      checkOutput($sformatf("dut%0d_res_valid_in_time", w), int'(res_valid[w]), 1);
      if (res_valid[w]) begin
         checkOutput($sformatf("dut%0d_res_safe", w), int'(res_safe[w]), int'(s));
         checkOutput($sformatf("dut%0d_res_dampened", w), int'(res_dampened[w]), int'(d));
         checkOutput($sformatf("dut%0d_res_overflow", w), int'(res_overflow[w]), int'(o));
         if (s) begin
            if (expSafe[w] < sat) expSafe[w]++;
         end else begin
            if (expUnsafe[w] < sat) expUnsafe[w]++;
         end
         @(negedge clk);
         checkOutput($sformatf("dut%0d_res_valid_pulse", w), int'(res_valid[w]), 0);
         checkOutput($sformatf("dut%0d_res_safe_hold", w), int'(res_safe[w]), int'(s));
         checkOutput($sformatf("dut%0d_safe_count", w), getSafe(w), expSafe[w]);
         checkOutput($sformatf("dut%0d_unsafe_count", w), getUnsafe(w), expUnsafe[w]);
      end
   endtask

   task automatic randomReport(output int q[$]);
      int len, v, dir, r;
      q   = {};
      len = int'($urandom_range(1, 18));
      v   = int'($urandom_range(0, 255));
      dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
      q.push_back(v);
      for (int i = 1; i < len; i++) begin
         r = int'($urandom_range(0, 11));
         if (r == 0) v = int'($urandom_range(0, 255));
         else if (r == 1) v = v + int'($urandom_range(0, 8)) - 4;
         else v = v + dir * int'($urandom_range(1, 3));
         if (v < 0) v = 0;
         if (v > 255) v = 255;
         q.push_back(v);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < 4; i++) begin
         expSafe[i]   = 0;
         expUnsafe[i] = 0;
      end
   endtask

   initial begin
      int q[$];
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid[i] = 1'b0;
         in_data[i]  = 8'd0;
         in_last[i]  = 1'b0;
      end
      clearModel();
      repeat (3) @(negedge clk);
      checkOutput("reset_in_ready", int'(in_ready[0]), 0);
      checkOutput("reset_res_valid", int'(res_valid[0]), 0);
      checkOutput("reset_res_safe", int'(res_safe[0]), 0);
      checkOutput("reset_safe_count", getSafe(0), 0);
      checkOutput("reset_unsafe_count", getUnsafe(0), 0);
      rst = 1'b0;
      #1;
      checkOutput("release_in_ready", int'(in_ready[0]), 1);

      runReport(0, '{7, 6, 4, 2, 1});
      runReport(0, '{1, 2, 7, 8, 9});
      runReport(0, '{9, 7, 6, 2, 1});
      runReport(0, '{1, 3, 2, 4, 5});
      runReport(0, '{8, 6, 4, 4, 1});
      runReport(0, '{9, 1, 2, 3, 4});
      runReport(0, '{5});
      runReport(0, '{254, 255, 1});
      runReport(1, '{1, 3, 2, 4, 5});
      runReport(1, '{8, 6, 4, 4, 1});
      runReport(2, '{1, 2, 3, 4, 5});
      runReport(2, '{1, 2});
      for (int i = 0; i < 5; i++) runReport(3, '{1, 2});
      checkOutput("dut3_saturated", getSafe(3), 3);

      for (int i = 0; i < 30; i++) begin
         randomReport(q);
         runReport(0, q);
      end
      for (int i = 0; i < 10; i++) begin
         randomReport(q);
         runReport(1, q);
      end

      applyStimulus(3, '{4, 5}, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      clearModel();
      checkOutput("midrst_dut3_safe_count", getSafe(3), 0);
      checkOutput("midrst_dut0_safe_count", getSafe(0), 0);
      checkOutput("midrst_dut0_unsafe_count", getUnsafe(0), 0);
      checkOutput("midrst_in_ready", int'(in_ready[3]), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("midrst_release_in_ready", int'(in_ready[3]), 1);
      runReport(3, '{6, 8});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/report_checker.md
REPORT_CHECKER -- requirements
Module: report_checker

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the level value width in bits (unsigned).
REQ-002 The block SHALL have the parameter MAX_LEVELS, default 16, giving the level buffer depth per report.
REQ-003 The block SHALL have the parameters MIN_STEP, default 1, and MAX_STEP, default 3, giving the inclusive bounds on the absolute adjacent difference.
REQ-004 The block SHALL have the parameter DAMPEN, default 1, where 1 permits removal of one level to make a report safe.
REQ-005 The block SHALL have the parameter CNT_W, default 16, giving the result counter width.
REQ-006 The block SHALL have the port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have the port in_valid, input, 1 bit: a level is offered.
REQ-009 The block SHALL have the port in_ready, output, 1 bit: the block accepts a level; a beat transfers when in_valid and in_ready are both high.
REQ-010 The block SHALL have the port in_data, input, WIDTH bits: the level value.
REQ-011 The block SHALL have the port in_last, input, 1 bit: the beat is the final level of its report.
REQ-012 The block SHALL have the port res_valid, output, 1 bit: a one-cycle pulse presenting the result.
REQ-013 The block SHALL have the port res_safe, output, 1 bit: the report is safe, meaningful when res_valid is high.
REQ-014 The block SHALL have the port res_dampened, output, 1 bit: the report is safe only after removing one level.
REQ-015 The block SHALL have the port res_overflow, output, 1 bit: the report exceeded MAX_LEVELS.
REQ-016 The block SHALL have the port safe_count, output, CNT_W bits: the running count of safe reports.
REQ-017 The block SHALL have the port unsafe_count, output, CNT_W bits: the running count of unsafe reports.

Function
REQ-018 The FSM SHALL have the states COLLECT, EVAL and RESULT, and SHALL enter COLLECT on reset.
REQ-019 In COLLECT, in_ready SHALL be 1, and each accepted beat SHALL be stored at the next buffer index while the level count n increments.
REQ-020 When an accepted beat has in_last=1, the FSM SHALL go to EVAL on the next edge; in_ready SHALL be 0 in EVAL and RESULT.
REQ-021 Beats beyond MAX_LEVELS SHALL be accepted and discarded, and SHALL set the overflow flag for the current report.
REQ-022 An adjacent pair (a,b) SHALL be valid when a!=b and MIN_STEP<=|b-a|<=MAX_STEP, with the difference computed in WIDTH+1 bits so that no wrap-around occurs.
REQ-023 A sequence SHALL be safe when all pairs are valid and all share the direction of the first pair; a sequence of fewer than 2 levels SHALL be safe.
REQ-024 Pass 0 SHALL evaluate all n levels.
REQ-025 If pass 0 fails and DAMPEN=1, passes k=0..n-1 SHALL each evaluate the sequence with index k skipped, stopping at the first safe pass.
REQ-026 EVAL SHALL process at most one pair per cycle; a pass MAY terminate early at its first invalid pair.
REQ-027 The report SHALL be safe if any pass is safe.
REQ-028 res_dampened SHALL be 1 only when pass 0 failed and a skip pass succeeded.
REQ-029 An overflowed report SHALL be unsafe, with res_overflow=1 and no passes evaluated.
REQ-030 res_valid SHALL pulse for exactly one cycle in RESULT, no later than (n+1)*(n+1)+2 cycles after the last beat is accepted.
REQ-031 The FSM SHALL return to COLLECT on the cycle after RESULT, with n and the overflow flag cleared.
REQ-032 In the RESULT cycle, exactly one of safe_count or unsafe_count SHALL increment; each counter SHALL saturate at all-ones.
REQ-033 res_safe, res_dampened and res_overflow SHALL hold their values until the next res_valid.
REQ-034 in_valid while in_ready=0 SHALL have no effect.

Reset
REQ-035 While rst=1, in_ready, res_valid, res_safe, res_dampened, res_overflow, safe_count, unsafe_count, n and the FSM SHALL be 0/COLLECT immediately, independent of clk.
REQ-036 A reset mid-report or mid-EVAL SHALL discard that report with no counter update.
REQ-037 in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-038 Defaults, report 7,6,4,2,1 -> res_safe=1, res_dampened=0, safe_count=1.
REQ-039 Reports 1,2,7,8,9 and 9,7,6,2,1 -> both res_safe=0, unsafe_count=2.
REQ-040 Reports 1,3,2,4,5 and 8,6,4,4,1 -> res_safe=1, res_dampened=1 each; with DAMPEN=0 -> res_safe=0 each.
REQ-041 Report 9,1,2,3,4, where the first level must be removed -> res_safe=1, res_dampened=1; a single-level report 5 -> res_safe=1.
REQ-042 MAX_LEVELS=4, report 1,2,3,4,5 -> res_overflow=1, res_safe=0; the next report 1,2 -> res_safe=1, res_overflow=0.
REQ-043 With CNT_W=2, five safe reports -> safe_count=3; rst asserted mid-report -> counters=0 at once, in_ready=1 after release.
